dma: RTL and testbench
======================

// Module: dma
// PURPOSE
//  Memory-to-memory DMA engine on the aux peripheral bus. The CPU programs
//  source, destination and length registers at 0x0100-0x0105, then writes
//  0x0100 to start. The block copies bytes over the shared external data-memory
//  port and raises irq when the copy is done. irq stays high until the CPU acks.
// PARAMETERS
//  BASE   16'h0100  aux address of the START register; the register window is BASE..BASE+5
// PORTS
//  clk         in   1   system clock, rising edge
//  rst         in   1   asynchronous, active-low reset
//  auxdaddr    in   16  aux bus address; a register write occurs every cycle it hits the window
//  auxdin      in   8   aux bus write data
//  extdout     in   8   read data from external memory (1-cycle synchronous read)
//  ack         in   1   CPU interrupt acknowledge, 1-cycle pulse
//  irq         out  1   transfer-complete interrupt, held until ack
//  auxdoutsel  out  1   1 = DMA owns the external memory port (mux select)
//  extdin      out  8   write data to external memory
//  extdaddr    out  16  external memory address
//  extwe       out  1   external memory write enable
//  state       out  3   debug: FSM state
//  counter     out  16  debug: bytes transferred so far
//  numbytes    out  16  debug: total bytes = (n+1)<<2
// BEHAVIOUR
//  Reset (async, rst=0): all registers 0, state=IDLE. irq, auxdoutsel, extwe = 0.
//    extdin and extdaddr = 0. counter and numbytes = 0.
//  Register map (writes accepted only in IDLE; no strobe, address match = write):
//    BASE+1 src[7:0]   BASE+2 src[15:8]   BASE+3 dst[7:0]   BASE+4 dst[15:8]
//    BASE+5 n[7:0]; numbytes = ({8'b0,n}+1)<<2  (n=3 -> 16, n=255 -> 1024)
//    BASE+0 START (data ignored): in IDLE -> counter=0, go to READ.
//  States (3-bit encoding): IDLE=0, READ=1, LATCH=2, WRITE=3, DONE=4.
//    READ : extdaddr=src+counter, extwe=0 -> LATCH
//    LATCH: capture extdout into data reg -> WRITE
//    WRITE: extdaddr=dst+counter, extdin=data, extwe=1; counter++;
//           if counter+1==numbytes -> DONE else -> READ
//    DONE : irq=1, auxdoutsel=0; ack=1 -> IDLE (irq drops next cycle)
//  Timing: 3 cycles per byte; 16 bytes = 48 cycles from START to DONE.
//  auxdoutsel=1 in READ/LATCH/WRITE, else 0. extwe=1 only in WRITE.
//  Outputs are registered or decoded from state; no combinational path aux->ext.
//  Edge rules:
//    START held for several cycles: only the first cycle counts.
//    START or register writes while busy or in DONE: ignored.
//    ack outside DONE: ignored.
//    Address arithmetic is 16-bit and wraps (0xFFFF+1 -> 0x0000).
//    Overlapping src/dst: copy is strictly ascending, no special handling.
//    rst asserted mid-transfer: immediate abort to IDLE with outputs at reset values.
// STRUCTURE
//  Shared package holds: state enum/localparams (IDLE..DONE) and register offsets
//    (START=0, SRC_L=1, SRC_H=2, DST_L=3, DST_H=4, LEN=5).
//  Single module; the register file, FSM and address generator are inline.
//    No sub-module is needed.
// TESTING
//  1. Reset then program src=0x0020, dst=0x0030, n=3, START.
//     -> 16 writes to 0x0030..0x003F with bytes read from 0x0020..0x002F.
//     -> irq=1 at cycle 48, numbytes=16.
//  2. ack pulse in DONE -> irq=0 and state=IDLE the next cycle.
//     An ack before DONE leaves the transfer unaffected.
//  3. START held 2 cycles -> exactly one transfer.
//     Writing n=7 during the transfer does not change numbytes (stays 16).
//  4. src=0xFFFE, n=0 -> 4 reads at 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap).
//  5. rst=0 at mid-transfer (counter=5) -> state=0, extwe=0, auxdoutsel=0.
//     irq stays 0; reprogram and restart succeeds.
//  6. n=255 -> numbytes=1024, irq after 3072 cycles, counter=1024 at DONE.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the memory-to-memory DMA engine:
// FSM state encoding and aux register offsets.
package dma_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_LATCH = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [2:0] OFF_START = 3'd0;
   localparam logic [2:0] OFF_SRC_L = 3'd1;
   localparam logic [2:0] OFF_SRC_H = 3'd2;
   localparam logic [2:0] OFF_DST_L = 3'd3;
   localparam logic [2:0] OFF_DST_H = 3'd4;
   localparam logic [2:0] OFF_LEN   = 3'd5;
   localparam logic [15:0] NUM_REGS = 16'd6;

endpackage

// File: rtl/dma.sv
// Memory-to-memory byte copy engine programmed over the aux bus.
// Ports: clk/rst (async active-low), aux write bus (auxdaddr, auxdin),
// external memory port (extdout in; extdin, extdaddr, extwe, auxdoutsel out),
// irq/ack interrupt handshake, debug state/counter/numbytes.
module dma
   import dma_pkg::*;
#(
   parameter logic [15:0] BASE = 16'h0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] auxdaddr,
   input  logic [7:0]  auxdin,
   input  logic [7:0]  extdout,
   input  logic        ack,
   output logic        irq,
   output logic        auxdoutsel,
   output logic [7:0]  extdin,
   output logic [15:0] extdaddr,
   output logic        extwe,
   output logic [2:0]  state,
   output logic [15:0] counter,
   output logic [15:0] numbytes
);

   state_t      state_q, state_d;
   logic [15:0] src_q, src_d;
   logic [15:0] dst_q, dst_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] nb_q, nb_d;
   logic [7:0]  data_q, data_d;
   logic [15:0] off;
   logic        hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         nb_q    <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         nb_q    <= nb_d;
         data_q  <= data_d;
      end
   end

   // Window decode: a wrapped subtraction makes the range test one compare.
   always_comb begin
      off = auxdaddr - BASE;
      hit = (off < NUM_REGS);
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      nb_d    = nb_q;
      data_d  = data_q;
      unique case (state_q)
         S_IDLE: begin
            if (hit) begin
               case (off[2:0])
                  OFF_START: begin
                     cnt_d   = '0;
                     state_d = S_READ;
                  end
                  OFF_SRC_L: src_d[7:0]  = auxdin;
                  OFF_SRC_H: src_d[15:8] = auxdin;
                  OFF_DST_L: dst_d[7:0]  = auxdin;
                  OFF_DST_H: dst_d[15:8] = auxdin;
                  OFF_LEN:   nb_d = ({8'b0, auxdin} + 16'd1) << 2;
                  default:   ;
               endcase
            end
         end
         S_READ:  state_d = S_LATCH;
         S_LATCH: begin
            data_d  = extdout;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            cnt_d   = cnt_q + 16'd1;
            state_d = (cnt_q + 16'd1 == nb_q) ? S_DONE : S_READ;
         end
         S_DONE: begin
            if (ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // External port is decoded purely from state and registers.
   always_comb begin
      extdaddr = '0;
      extdin   = '0;
      unique case (state_q)
         S_READ, S_LATCH: extdaddr = src_q + cnt_q;
         S_WRITE: begin
            extdaddr = dst_q + cnt_q;
            extdin   = data_q;
         end
         default: ;
      endcase
   end

   assign extwe      = (state_q == S_WRITE);
   assign auxdoutsel = (state_q == S_READ) ||
                       (state_q == S_LATCH) ||
                       (state_q == S_WRITE);
   assign irq        = (state_q == S_DONE);
   assign state      = state_q;
   assign counter    = cnt_q;
   assign numbytes   = nb_q;

endmodule

// File: tb/tb_dma.sv
// Scoreboard bench for the DMA engine: a reference copy model fills
// expected read/write queues, a negedge monitor pops and compares.
module tb_dma;

   localparam logic [15:0] BASE = 16'h0100;

   logic        clk;
   logic        rst;
   logic [15:0] auxdaddr;
   logic [7:0]  auxdin;
   logic [7:0]  extdout;
   logic        ack;
   logic        irq;
   logic        auxdoutsel;
   logic [7:0]  extdin;
   logic [15:0] extdaddr;
   logic        extwe;
   logic [2:0]  state;
   logic [15:0] counter;
   logic [15:0] numbytes;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_ra[$];
   logic [23:0] exp_w[$];

   logic [7:0] mem[65536];
   bit         vld[65536];
   logic [7:0] rmem[65536];
   bit         rvld[65536];

   dma #(.BASE(BASE)) dut (
      .clk(clk), .rst(rst),
      .auxdaddr(auxdaddr), .auxdin(auxdin),
      .extdout(extdout), .ack(ack),
      .irq(irq), .auxdoutsel(auxdoutsel),
      .extdin(extdin), .extdaddr(extdaddr),
      .extwe(extwe), .state(state),
      .counter(counter), .numbytes(numbytes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ib(input logic [15:0] a);
      return (a[7:0] * 8'd29) ^ a[15:8] ^ 8'h5A;
   endfunction

   // External memory: synchronous read, write on extwe.
   always @(posedge clk) begin
      if (extwe) begin
         mem[extdaddr] <= extdin;
         vld[extdaddr] <= 1'b1;
      end
      extdout <= vld[extdaddr] ? mem[extdaddr] : ib(extdaddr);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Monitor
   initial begin
      logic [23:0] w;
      forever begin
         @(negedge clk);
         if (rst && state == 3'd1) begin
            if (exp_ra.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rd_unexpected actual=%0h required=none",
                        extdaddr);
            end else begin
               chk("rd_addr", extdaddr, exp_ra.pop_front());
            end
         end
         if (rst && extwe) begin
            if (exp_w.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wr_unexpected actual=%0h required=none",
                        extdaddr);
            end else begin
               w = exp_w.pop_front();
               chk("wr_addr", extdaddr, w[23:8]);
               chk("wr_data", extdin, w[7:0]);
            end
         end
      end
   end

   task automatic wr(input logic [15:0] a, input logic [7:0] v);
      auxdaddr = a;
      auxdin   = v;
      @(posedge clk);
      #1;
      auxdaddr = 16'h0000;
   endtask

   task automatic xfer(input logic [15:0] s, input logic [15:0] d,
                       input logic [7:0] n, input int start_cyc,
                       input bit poke, input int abort_at);
      int nb;
      int cyc;
      bit done;
      logic [15:0] sa;
      logic [15:0] da;
      logic [7:0]  v;
      nb = (int'(n) + 1) * 4;
      wr(BASE + 16'd1, s[7:0]);
      wr(BASE + 16'd2, s[15:8]);
      wr(BASE + 16'd3, d[7:0]);
      wr(BASE + 16'd4, d[15:8]);
      wr(BASE + 16'd5, n);
      for (int i = 0; i < nb; i++) begin
         sa = s + 16'(i);
         da = d + 16'(i);
         v  = rvld[sa] ? rmem[sa] : ib(sa);
         exp_ra.push_back(sa);
         exp_w.push_back({da, v});
         rmem[da] = v;
         rvld[da] = 1'b1;
      end
      auxdaddr = BASE;
      @(posedge clk);
      #1;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 3 * nb + 20) begin
         auxdaddr = (cyc < start_cyc - 1) ? BASE : 16'h0000;
         if (poke) begin
            if (cyc == 5) begin
               auxdaddr = BASE + 16'd5;
               auxdin   = 8'd7;
            end
            ack = (cyc == 10);
         end
         if (abort_at >= 0 && counter == 16'(abort_at)) begin
            rst = 1'b0;
            #1;
            exp_ra.delete();
            exp_w.delete();
            chk("abort_state", state, 0);
            chk("abort_extwe", extwe, 0);
            chk("abort_sel", auxdoutsel, 0);
            chk("abort_irq", irq, 0);
            chk("abort_cnt", counter, 0);
            chk("abort_addr", extdaddr, 0);
            @(posedge clk);
            #1;
            rst = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            chk("post_abort_irq", irq, 0);
            chk("post_abort_state", state, 0);
            return;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (irq) done = 1'b1;
      end
      ack      = 1'b0;
      auxdaddr = 16'h0000;
      chk("done_cycles", cyc, 3 * nb);
      chk("done_state", state, 4);
      chk("done_counter", counter, nb);
      chk("done_numbytes", numbytes, nb);
      chk("done_sel", auxdoutsel, 0);
      chk("done_extwe", extwe, 0);
      chk("rd_left", exp_ra.size(), 0);
      chk("wr_left", exp_w.size(), 0);
      auxdaddr = BASE;
      @(posedge clk);
      #1;
      auxdaddr = 16'h0000;
      chk("start_in_done", state, 4);
      chk("irq_held", irq, 1);
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
      chk("ack_irq", irq, 0);
      chk("ack_state", state, 0);
   endtask

   initial begin
      logic [15:0] s;
      logic [15:0] d;
      rst      = 1'b0;
      ack      = 1'b0;
      auxdaddr = 16'h0000;
      auxdin   = 8'h00;
      #1;
      chk("rst_state", state, 0);
      chk("rst_irq", irq, 0);
      chk("rst_sel", auxdoutsel, 0);
      chk("rst_extwe", extwe, 0);
      chk("rst_extdin", extdin, 0);
      chk("rst_extdaddr", extdaddr, 0);
      chk("rst_counter", counter, 0);
      chk("rst_numbytes", numbytes, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      xfer(16'h0020, 16'h0030, 8'd3, 1, 1'b0, -1);
      xfer(16'h0040, 16'h0060, 8'd3, 2, 1'b1, -1);
      xfer(16'hFFFE, 16'h0200, 8'd0, 1, 1'b0, -1);
      xfer(16'h4000, 16'h5000, 8'd3, 1, 1'b0, 5);
      xfer(16'h4000, 16'h5100, 8'd3, 1, 1'b0, -1);
      for (int k = 0; k < 5; k++) begin
         s = 16'h8000 + 16'($urandom_range(0, 16'h3000));
         if ($urandom_range(0, 1) == 1)
            d = s + 16'($urandom_range(1, 8));
         else
            d = 16'hC000 + 16'($urandom_range(0, 16'h2000));
         xfer(s, d, 8'($urandom_range(0, 7)),
              int'($urandom_range(1, 3)), 1'b0, -1);
      end
      xfer(16'h1000, 16'h2000, 8'd255, 1, 1'b0, -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
